// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use/no-forward stalls,
// branch flush and memory-wait freeze for a five-stage in-order pipeline.

package pipe_ctrl_pkg;
   localparam int unsigned REG_W = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 16;

   localparam logic [SEL_W-1:0] SEL_RF  = 2'd0;
   localparam logic [SEL_W-1:0] SEL_ALU = 2'd1;
   localparam logic [SEL_W-1:0] SEL_WB  = 2'd2;

   // Shadow of the instruction occupying one downstream stage
   typedef struct packed {
      logic             valid;
      logic             wb_en;
      logic [REG_W-1:0] dest;
      logic             mem_op;
      logic             mem_r;
   } slot_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;
endpackage

module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_use1,
   input  logic             id_two_src,
   input  logic             id_wb_en,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_mem_r,
   input  logic             id_mem_w,
   input  logic             fwd_en,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic [SEL_W-1:0] sel_src1,
   output logic [SEL_W-1:0] sel_src2,
   output logic             hazard_stall,
   output logic             flush,
   output logic             freeze,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   slot_t            exs_q, exs_d;
   slot_t            mems_q, mems_d;
   logic [SEL_W-1:0] sel_src1_q, sel_src1_d;
   logic [SEL_W-1:0] sel_src2_q, sel_src2_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   state_t           state_q, state_d;

   logic             ex_hit1, ex_hit2, mem_hit1, mem_hit2;
   logic             raw_hazard;
   logic             bubble;
   logic [SEL_W-1:0] nsel1, nsel2;
   slot_t            id_slot;

   function automatic logic src_match(input logic used, input logic [REG_W-1:0] src,
                                      input slot_t s);
      return used & s.valid & s.wb_en & (s.dest == src);
   endfunction

   // Nearest producer wins: EXE/MEM result is younger than the WB value
   function automatic logic [SEL_W-1:0] fwd_sel(input logic en, input logic ex_hit,
                                                input logic mem_hit);
      if (!en)     return SEL_RF;
      if (ex_hit)  return SEL_ALU;
      if (mem_hit) return SEL_WB;
      return SEL_RF;
   endfunction

   always_comb begin
      ex_hit1  = src_match(id_use1,    id_src1, exs_q);
      ex_hit2  = src_match(id_two_src, id_src2, exs_q);
      mem_hit1 = src_match(id_use1,    id_src1, mems_q);
      mem_hit2 = src_match(id_two_src, id_src2, mems_q);
      nsel1    = fwd_sel(fwd_en, ex_hit1, mem_hit1);
      nsel2    = fwd_sel(fwd_en, ex_hit2, mem_hit2);

      if (fwd_en) raw_hazard = id_valid & exs_q.mem_r & (ex_hit1 | ex_hit2);
      else        raw_hazard = id_valid & (ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2);

      // Priority freeze > flush > stall
      freeze       = mems_q.valid & mems_q.mem_op & ~mem_ready;
      flush        = branch_taken & ~freeze;
      hazard_stall = raw_hazard & ~freeze & ~flush;
      bubble       = flush | hazard_stall | ~id_valid;

      id_slot = '{valid:  1'b1,
                  wb_en:  id_wb_en,
                  dest:   id_dest,
                  mem_op: id_mem_r | id_mem_w,
                  mem_r:  id_mem_r};
   end

   always_comb begin
      exs_d       = exs_q;
      mems_d      = mems_q;
      sel_src1_d  = sel_src1_q;
      sel_src2_d  = sel_src2_q;
      stall_cnt_d = stall_cnt_q;
      state_d     = state_q;

      if (!freeze) begin
         mems_d = exs_q;
         if (bubble) begin
            exs_d      = '0;
            sel_src1_d = SEL_RF;
            sel_src2_d = SEL_RF;
         end else begin
            exs_d      = id_slot;
            sel_src1_d = nsel1;
            sel_src2_d = nsel2;
         end
      end

      if ((freeze | hazard_stall) && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);

      case (state_q)
         RUN:      if (freeze)    state_d = MEM_WAIT;
         MEM_WAIT: if (mem_ready) state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         exs_q       <= '0;
         mems_q      <= '0;
         sel_src1_q  <= SEL_RF;
         sel_src2_q  <= SEL_RF;
         stall_cnt_q <= '0;
         state_q     <= RUN;
      end else begin
         exs_q       <= exs_d;
         mems_q      <= mems_d;
         sel_src1_q  <= sel_src1_d;
         sel_src2_q  <= sel_src2_d;
         stall_cnt_q <= stall_cnt_d;
         state_q     <= state_d;
      end
   end

   assign sel_src1  = sel_src1_q;
   assign sel_src2  = sel_src2_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed instruction sequences with hand-computed
// per-cycle expectations queued by the driver and checked by an independent monitor.

module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   typedef struct packed {
      logic       valid;
      logic [3:0] src1;
      logic [3:0] src2;
      logic       use1;
      logic       two;
      logic       wb;
      logic [3:0] dest;
      logic       mr;
      logic       mw;
   } instr_t;

   typedef struct packed {
      logic [1:0]  s1;
      logic [1:0]  s2;
      logic        hs;
      logic        fl;
      logic        fz;
      logic [15:0] cnt;
      logic        wt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid = 1'b0, id_use1 = 1'b0, id_two_src = 1'b0, id_wb_en = 1'b0;
   logic [3:0]  id_src1 = '0, id_src2 = '0, id_dest = '0;
   logic        id_mem_r = 1'b0, id_mem_w = 1'b0;
   logic        fwd_en = 1'b1, branch_taken = 1'b0, mem_ready = 1'b1;
   logic [1:0]  sel_src1, sel_src2;
   logic        hazard_stall, flush, freeze;
   logic [15:0] stall_cnt;

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   string       name_q[$];

   pipe_ctrl dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_use1(id_use1), .id_two_src(id_two_src), .id_wb_en(id_wb_en),
      .id_dest(id_dest), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
      .fwd_en(fwd_en), .branch_taken(branch_taken), .mem_ready(mem_ready),
      .sel_src1(sel_src1), .sel_src2(sel_src2),
      .hazard_stall(hazard_stall), .flush(flush), .freeze(freeze),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic instr_t nop();
      return '0;
   endfunction

   function automatic instr_t alu(input logic [3:0] d, input logic [3:0] s1,
                                  input logic [3:0] s2, input logic two);
      instr_t i;
      i = '0;
      i.valid = 1'b1; i.wb = 1'b1; i.dest = d;
      i.src1 = s1; i.use1 = 1'b1; i.src2 = s2; i.two = two;
      return i;
   endfunction

   function automatic instr_t ldr(input logic [3:0] d, input logic [3:0] s1);
      instr_t i;
      i = alu(d, s1, 4'd0, 1'b0);
      i.mr = 1'b1;
      return i;
   endfunction

   function automatic instr_t str(input logic [3:0] base, input logic [3:0] data);
      instr_t i;
      i = alu(4'd0, base, data, 1'b1);
      i.wb = 1'b0; i.mw = 1'b1;
      return i;
   endfunction

   function automatic instr_t cmp(input logic [3:0] d, input logic [3:0] s1);
      instr_t i;
      i = alu(d, s1, 4'd0, 1'b0);
      i.wb = 1'b0;
      return i;
   endfunction

   function automatic exp_t ex(input logic [1:0] s1, input logic [1:0] s2, input logic hs,
                               input logic fl, input logic fz, input logic [15:0] cnt,
                               input logic wt);
      return '{s1: s1, s2: s2, hs: hs, fl: fl, fz: fz, cnt: cnt, wt: wt};
   endfunction

   // Drive one cycle of inputs and queue what the outputs must show during that cycle
   task automatic cyc(input string nm, input instr_t i, input logic fw, input logic br,
                      input logic mr, input logic rs, input exp_t e);
      rst = rs;
      id_valid = i.valid; id_src1 = i.src1; id_src2 = i.src2;
      id_use1 = i.use1; id_two_src = i.two; id_wb_en = i.wb; id_dest = i.dest;
      id_mem_r = i.mr; id_mem_w = i.mw;
      fwd_en = fw; branch_taken = br; mem_ready = mr;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input string f, input logic [15:0] act,
                      input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s actual=%0h expected=%0h", nm, f, act, req);
      end
   endtask

   initial begin : monitor
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "sel_src1",     16'(sel_src1),     16'(e.s1));
            chk(nm, "sel_src2",     16'(sel_src2),     16'(e.s2));
            chk(nm, "hazard_stall", 16'(hazard_stall), 16'(e.hs));
            chk(nm, "flush",        16'(flush),        16'(e.fl));
            chk(nm, "freeze",       16'(freeze),       16'(e.fz));
            chk(nm, "stall_cnt",    stall_cnt,         e.cnt);
            chk(nm, "mem_wait",     16'(dut.state_q == MEM_WAIT), 16'(e.wt));
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin : stimulus
      int n;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      //        name          instr               fw    br    mr    rs    s1 s2 hs fl fz cnt wt
      cyc("rst_rel",    nop(),               1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("add_r1",     alu(1, 2, 3, 1),     1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("sub_r1",     alu(5, 1, 6, 1),     1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("sub_exe",    nop(),               1'b1, 1'b0, 1'b1, 1'b1, ex(1, 0, 0, 0, 0, 0, 0));
      cyc("add_r2",     alu(2, 0, 0, 0),     1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("nop_gap",    nop(),               1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("orr_r2",     alu(7, 8, 2, 1),     1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("orr_exe",    nop(),               1'b1, 1'b0, 1'b1, 1'b1, ex(0, 2, 0, 0, 0, 0, 0));
      cyc("cmp_nowb",   cmp(3, 1),           1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("use_nowb",   alu(10, 3, 3, 1),    1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("same_src",   alu(11, 10, 10, 1),  1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("same_exe",   nop(),               1'b1, 1'b0, 1'b1, 1'b1, ex(1, 1, 0, 0, 0, 0, 0));
      cyc("ldr_r3",     ldr(3, 13),          1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
      cyc("lu_stall",   alu(12, 3, 14, 1),   1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 1, 0, 0, 0, 0));
      cyc("lu_fwd",     alu(12, 3, 14, 1),   1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 1, 0));
      cyc("lu_exe",     nop(),               1'b1, 1'b0, 1'b1, 1'b1, ex(2, 0, 0, 0, 0, 1, 0));
      cyc("add_r4",     alu(4, 0, 0, 0),     1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 1, 0));
      cyc("eor_st1",    alu(6, 4, 0, 0),     1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 1, 0, 0, 1, 0));
      cyc("eor_st2",    alu(6, 4, 0, 0),     1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 1, 0, 0, 2, 0));
      cyc("eor_go",     alu(6, 4, 0, 0),     1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 3, 0));
      cyc("eor_exe",    nop(),               1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 3, 0));
      cyc("add_r9",     alu(9, 6, 0, 0),     1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 3, 0));
      cyc("str_r9",     str(9, 9),           1'b1, 1'b0, 1'b1, 1'b1, ex(2, 0, 0, 0, 0, 3, 0));
      cyc("add_r13",    alu(13, 9, 5, 1),    1'b1, 1'b0, 1'b1, 1'b1, ex(1, 1, 0, 0, 0, 3, 0));
      cyc("frz1",       nop(),               1'b1, 1'b0, 1'b0, 1'b1, ex(2, 0, 0, 0, 1, 3, 0));
      cyc("frz2_haz",   alu(1, 13, 0, 0),    1'b0, 1'b0, 1'b0, 1'b1, ex(2, 0, 0, 0, 1, 4, 1));
      cyc("frz3_br",    nop(),               1'b1, 1'b1, 1'b0, 1'b1, ex(2, 0, 0, 0, 1, 5, 1));
      cyc("mem_done",   nop(),               1'b1, 1'b0, 1'b1, 1'b1, ex(2, 0, 0, 0, 0, 6, 1));
      cyc("run_again",  nop(),               1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 6, 0));
      cyc("ldr_r5",     ldr(5, 0),           1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 6, 0));
      cyc("br_lu",      alu(7, 5, 0, 0),     1'b1, 1'b1, 1'b1, 1'b1, ex(0, 0, 0, 1, 0, 6, 0));
      cyc("post_flush", ldr(2, 7),           1'b0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 6, 0));
      cyc("ldr_exe",    nop(),               1'b1, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 6, 0));
      cyc("wait1",      nop(),               1'b1, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 1, 6, 0));
      cyc("wait2",      nop(),               1'b1, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 1, 7, 1));
      cyc("rst_mid",    nop(),               1'b1, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 1, 8, 1));
      cyc("after_rst",  nop(),               1'b1, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));

      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
